// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/subtract split into STAGES ripple segments with registered carries,
// valid/ready on both sides. Define ADDER_PIPE_SAT_EN for WIDTH-bit saturating results.
module adder_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             out_sub
);
    localparam int unsigned SEG = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] bx;

    // Subtraction runs as a + ~b + 1; the +1 enters as segment 0's carry-in.
    assign bx = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                 vld_q, vld_d, sub_q, sub_d;
        logic [SEG-1:0]       seg_a, seg_b;
        logic                 carry_in, vld_in, sub_in;
        logic [SEG:0]         seg_sum;
        logic [(k+1)*SEG-1:0] acc_r;

        if (k == 0) begin : g_src
            assign seg_a    = a[SEG-1:0];
            assign seg_b    = bx[SEG-1:0];
            assign carry_in = sub;
            assign vld_in   = in_valid;
            assign sub_in   = sub;
            assign acc_r    = seg_sum[SEG-1:0];
        end else begin : g_src
            assign seg_a    = g_stage[k-1].g_mid.opa_q[k*SEG +: SEG];
            assign seg_b    = g_stage[k-1].g_mid.opb_q[k*SEG +: SEG];
            assign carry_in = g_stage[k-1].g_mid.cy_q;
            assign vld_in   = g_stage[k-1].vld_q;
            assign sub_in   = g_stage[k-1].sub_q;
            assign acc_r    = {seg_sum[SEG-1:0], g_stage[k-1].g_mid.res_q};
        end

        assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_in};

        always_comb begin
            vld_d = adv ? vld_in : vld_q;
            sub_d = adv ? sub_in : sub_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                sub_q <= 1'b0;
            end else begin
                vld_q <= vld_d;
                sub_q <= sub_d;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            // Skew registers keep only the operand segments not yet consumed.
            logic [WIDTH-1:(k+1)*SEG] fwd_a, fwd_b, opa_q, opa_d, opb_q, opb_d;
            logic [(k+1)*SEG-1:0]     res_q, res_d;
            logic                     cy_q, cy_d;

            if (k == 0) begin : g_fwd
                assign fwd_a = a[WIDTH-1:SEG];
                assign fwd_b = bx[WIDTH-1:SEG];
            end else begin : g_fwd
                assign fwd_a = g_stage[k-1].g_mid.opa_q[WIDTH-1:(k+1)*SEG];
                assign fwd_b = g_stage[k-1].g_mid.opb_q[WIDTH-1:(k+1)*SEG];
            end

            always_comb begin
                opa_d = adv ? fwd_a : opa_q;
                opb_d = adv ? fwd_b : opb_q;
                res_d = adv ? acc_r : res_q;
                cy_d  = adv ? seg_sum[SEG] : cy_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    res_q <= '0;
                    cy_q  <= 1'b0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    res_q <= res_d;
                    cy_q  <= cy_d;
                end
            end
        end else begin : g_last
            logic             msb;
            logic [WIDTH-1:0] low;
            logic [WIDTH:0]   sum_q, sum_d;

            always_comb begin
                // Inverted carry is the borrow flag of the (WIDTH+1)-bit difference.
                msb = sub_in ? ~seg_sum[SEG] : seg_sum[SEG];
                low = acc_r;
`ifdef ADDER_PIPE_SAT_EN
                if (msb) begin
                    low = sub_in ? '0 : '1;
                end
`endif
                sum_d = adv ? {msb, low} : sum_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q <= '0;
                end else begin
                    sum_q <= sum_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign out_sub   = g_stage[STAGES-1].sub_q;
    assign sum       = g_stage[STAGES-1].g_last.sum_q;
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (WIDTH=8, STAGES=2): vector tables, bubble/stall/reset sequences and a
// randomized run scored against a plain-arithmetic reference with a result queue.
module tb_adder_pipe;
    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W:0]   exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, sub, out_valid, out_ready, out_sub;
    logic [W-1:0] a, b;
    logic [W:0]   sum;

    int         checks = 0;
    int         errors = 0;
    int         starve = 0;
    logic [W:0] exp_q[$];
    logic       exp_s_q[$];

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .out_sub  (out_sub)
    );

    function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        longint     t;
        logic [W:0] r;
        t = s ? longint'(x) - longint'(y) : longint'(x) + longint'(y);
        r = t[W:0];
`ifdef ADDER_PIPE_SAT_EN
        if (t > (longint'(1) << W) - 1) r = {1'b1, {W{1'b1}}};
        else if (t < 0) r = {1'b1, {W{1'b0}}};
        else r = {1'b0, t[W-1:0]};
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [W:0] got, input logic [W:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle of scoreboarded traffic; inputs are already driven at the falling edge.
    task automatic tick();
        #1;
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", out_valid, 1'b0);
            end else begin
                chk("stream_sum", sum, exp_q[0]);
                chk("stream_sub", out_sub, exp_s_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_s_q.pop_front());
                end
            end
            starve = 0;
        end else if (exp_q.size() > 0) begin
            starve++;
            chk("result_latency", starve < S, 1'b1);
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(a, b, sub));
            exp_s_q.push_back(sub);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4 * S + 4 && exp_q.size() > 0; k++) tick();
        chk("drained", exp_q.size() == 0, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time limit, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tab[10];
        vec_t       bub[4];
        logic [W:0] held;
        logic       hv[16];
        logic       hs[16];
        logic [W:0] he[16];

        tab[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
        tab[1] = '{8'h01, 8'h01, 1'b0, 9'h002};
        tab[2] = '{8'h06, 8'h03, 1'b0, 9'h009};
        tab[3] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tab[4] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE};
        tab[5] = '{8'h05, 8'h06, 1'b1, 9'h1FF};
        tab[6] = '{8'h0A, 8'h05, 1'b1, 9'h005};
        tab[7] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        tab[8] = '{8'h00, 8'hFF, 1'b1, 9'h101};
        tab[9] = '{8'h00, 8'h00, 1'b1, 9'h000};
`ifdef ADDER_PIPE_SAT_EN
        tab[3].exp = 9'h1FF;
        tab[4].exp = 9'h1FF;
        tab[5].exp = 9'h100;
        tab[8].exp = 9'h100;
`endif
        bub[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        bub[1] = '{8'h80, 8'h80, 1'b0, 9'h000};
        bub[2] = '{8'h7F, 8'h80, 1'b1, 9'h000};
        bub[3] = '{8'h33, 8'h44, 1'b0, 9'h000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_out_sub", out_sub, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Back-to-back stream: vector i shows at the falling edge S edges after it was driven.
        for (int j = 0; j < 10 + S; j++) begin
            if (j < 10) begin
                in_valid = 1'b1; a = tab[j].a; b = tab[j].b; sub = tab[j].s;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("tbl_in_ready", in_ready, 1'b1);
            if (j >= S) begin
                chk("tbl_valid", out_valid, 1'b1);
                chk("tbl_sum", sum, tab[j-S].exp);
                chk("tbl_sub", out_sub, tab[j-S].s);
            end else begin
                chk("tbl_fill_valid", out_valid, 1'b0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("tbl_empty", out_valid, 1'b0);

        // Alternating bubbles must come out with the same pattern, delayed by the latency.
        for (int j = 0; j < 8 + S; j++) begin
            hv[j] = (j < 8) && (j % 2 == 0);
            in_valid = hv[j];
            if (hv[j]) begin
                a = bub[j/2].a; b = bub[j/2].b; sub = bub[j/2].s;
                he[j] = ref_model(a, b, sub);
                hs[j] = sub;
            end else begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(1));
            end
            #1;
            if (j >= S) begin
                chk("bub_valid", out_valid, hv[j-S]);
                if (hv[j-S]) begin
                    chk("bub_sum", sum, he[j-S]);
                    chk("bub_sub", out_sub, hs[j-S]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("bub_carry_0f_01", ref_model(8'h0F, 8'h01, 1'b0), 9'h010);

        // Fill, then stall three cycles with a full pipeline.
        out_ready = 1'b1;
        for (int k = 0; k < S + 2; k++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(1));
            tick();
        end
        out_ready = 1'b0;
        in_valid  = 1'b1; a = 8'hA5; b = 8'h5A; sub = 1'b0;
        held = sum;
        chk("bp_pre_valid", out_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_sum_hold", sum, held);
            chk("bp_valid_hold", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        drain();

        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            case ($urandom_range(3))
                0: a = '1;
                1: a = '0;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(3))
                0: b = '1;
                1: b = '0;
                default: b = W'($urandom);
            endcase
            sub = 1'($urandom_range(1));
            tick();
        end
        drain();

        // Reset with stalled results in flight: everything clears at once, nothing reappears.
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < S + 1; k++) begin
            a = 8'h12 + W'(k); b = 8'h34; sub = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_in_ready", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_out_sub", out_sub, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < S + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
